// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared types and defaults for the ram_sequencer block.
//   state_t    - sequencer FSM states (CLEAR exists only with RAM_SEQ_CLEAR_EN)
//   req_t      - request bundle (we, addr, wdata) at the default widths
//   DATA_W_DEF - default word width
//   ADDR_W_DEF - default word address width
package ram_seq_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned ADDR_W_DEF = 6;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      RESP
`ifdef RAM_SEQ_CLEAR_EN
      , CLEAR
`endif
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;

endpackage

// File: rtl/ram_sequencer.sv
// ram_sequencer: single-outstanding request sequencer in front of a
// single-port RAM with combinational read data.
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake; req_we, req_addr, req_wdata
//   rsp_valid/rsp_ready   - read response handshake; rsp_rdata
//   mem_in, mem_addr,
//   mem_load, mem_out     - RAM port (write on clk edge while mem_load=1)
//   clr_start, clr_busy   - whole-RAM clear, present only when the macro
//                           RAM_SEQ_CLEAR_EN is defined
module ram_sequencer
   import ram_seq_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef RAM_SEQ_CLEAR_EN
   input  logic              clr_start,
   output logic              clr_busy,
`endif
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [DATA_W-1:0] mem_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_load,
   input  logic [DATA_W-1:0] mem_out
);

   state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
`ifdef RAM_SEQ_CLEAR_EN
            if (clr_start) state_d = CLEAR;
            else
`endif
            if (req_valid) state_d = req_we ? WRITE : READ;
         end
         WRITE: state_d = IDLE;
         READ:  state_d = RESP;
         RESP:  if (rsp_ready) state_d = IDLE;
`ifdef RAM_SEQ_CLEAR_EN
         // mem_addr doubles as the clear counter; stop at the top, no wrap
         CLEAR: if (mem_addr == '1) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
`ifdef RAM_SEQ_CLEAR_EN
   assign clr_busy  = (state_q == CLEAR);
   assign mem_load  = (state_q == WRITE) || (state_q == CLEAR);
`else
   assign mem_load  = (state_q == WRITE);
`endif

   // RAM address/data registers hold their value whenever not reloaded, so
   // they stay stable while idle and during READ/RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_in    <= '0;
         rsp_rdata <= '0;
      end else begin
         case (state_q)
            IDLE: begin
`ifdef RAM_SEQ_CLEAR_EN
               if (clr_start) begin
                  mem_addr <= '0;
                  mem_in   <= '0;
               end else
`endif
               if (req_valid) begin
                  mem_addr <= req_addr;
                  if (req_we) mem_in <= req_wdata;
               end
            end
            READ: rsp_rdata <= mem_out;
`ifdef RAM_SEQ_CLEAR_EN
            CLEAR: if (mem_addr != '1) mem_addr <= mem_addr + ADDR_W'(1);
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_sequencer.sv
// tb_ram_sequencer: directed self-checking bench for ram_sequencer paired
// with a 64 x 64-bit RAM model (ram64 behaviour: synchronous write while
// mem_load, combinational read). Clear tests build with RAM_SEQ_CLEAR_EN.
module tb_ram_sequencer;
   import ram_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [5:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_rdata;
   logic [63:0] mem_in;
   logic [5:0]  mem_addr;
   logic        mem_load;
   logic [63:0] mem_out;
`ifdef RAM_SEQ_CLEAR_EN
   logic        clr_start = 1'b0;
   logic        clr_busy;
`endif

   int checks = 0;
   int errors = 0;
   int load_cnt = 0;
   logic ram_init = 1'b1;
   logic [63:0] ram [64];

   always #5 clk = ~clk;

   ram_sequencer #(.DATA_W(64), .ADDR_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef RAM_SEQ_CLEAR_EN
      .clr_start(clr_start), .clr_busy(clr_busy),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .mem_in(mem_in), .mem_addr(mem_addr), .mem_load(mem_load), .mem_out(mem_out)
   );

   // RAM model
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) ram[i] <= '0;
      end else if (mem_load === 1'b1) begin
         ram[mem_addr] <= mem_in;
      end
   end
   assign mem_out = ram[mem_addr];

   always @(posedge clk) if (mem_load === 1'b1) load_cnt <= load_cnt + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [5:0] a, input logic [63:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      check("wr_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      check("wr_load", mem_load, 1);
      check("wr_addr", mem_addr, a);
      check("wr_data", mem_in, d);
      check("wr_busy", req_ready, 0);
   endtask

   task automatic do_read(input logic [5:0] a, input logic [63:0] exp, input int stall);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      rsp_ready = (stall == 0);
      check("rd_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      check("rd_noload", mem_load, 0);
      check("rd_addr", mem_addr, a);
      check("rd_novalid", rsp_valid, 0);
      @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_rdata, exp);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid", rsp_valid, 1);
         check("stall_data", rsp_rdata, exp);
         check("stall_ready", req_ready, 0);
      end
      if (stall > 0) begin
         rsp_ready = 1'b1;
         @(negedge clk);
         check("stall_release", req_ready, 1);
         check("stall_done", rsp_valid, 0);
      end
   endtask

   initial begin
      int base;
      int busy_cnt;
      int guard;

      // reset values
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_rvalid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_load", mem_load, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_in", mem_in, 0);
`ifdef RAM_SEQ_CLEAR_EN
      check("rst_busy", clr_busy, 0);
`endif
      @(negedge clk);
      ram_init = 1'b0;
      rst_n = 1'b1;

      // basic write then read
      do_write(6'd5, 64'hDEAD_BEEF_0123_4567);
      do_read(6'd5, 64'hDEAD_BEEF_0123_4567, 0);

      // stalled response
      do_read(6'd5, 64'hDEAD_BEEF_0123_4567, 4);

      // request presented while busy is ignored
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7; req_wdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      req_addr = 6'd8; req_wdata = 64'h5555_6666_7777_8888;
      check("ign_ready", req_ready, 0);
      check("ign_addr_w", mem_addr, 6'd7);
      @(negedge clk);
      req_valid = 1'b0;
      check("ign_addr_i", mem_addr, 6'd7);
      check("ign_data_i", mem_in, 64'h1111_2222_3333_4444);
      do_read(6'd8, 64'h0, 0);
      do_read(6'd7, 64'h1111_2222_3333_4444, 0);

      // reset during WRITE abandons the write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd9; req_wdata = 64'hCAFE_F00D_0000_0009;
      @(negedge clk);
      req_valid = 1'b0;
      check("rw_load_pre", mem_load, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rw_load", mem_load, 0);
      check("rw_addr", mem_addr, 0);
      check("rw_in", mem_in, 0);
      check("rw_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      do_read(6'd9, 64'h0, 0);

      // reset during RESP drops the response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rr_valid_pre", rsp_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rr_valid", rsp_valid, 0);
      check("rr_rdata", rsp_rdata, 0);
      check("rr_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rr_after", rsp_valid, 0);
      end

      // fill all addresses with addr*3 and read back
      base = load_cnt;
      for (int i = 0; i < 64; i++) do_write(6'(i), 64'(i * 3));
      @(negedge clk);
      check("fill_loads", 64'(load_cnt - base), 64);
      for (int i = 0; i < 64; i++) do_read(6'(i), 64'(i * 3), 0);

`ifdef RAM_SEQ_CLEAR_EN
      // clear wins over a simultaneous request
      for (int i = 0; i < 64; i++) do_write(6'(i), '1);
      @(negedge clk);
      clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd3; req_wdata = 64'd5;
      @(negedge clk);
      clr_start = 1'b0; req_valid = 1'b0;
      check("clr_busy", clr_busy, 1);
      check("clr_ready", req_ready, 0);
      check("clr_load", mem_load, 1);
      check("clr_addr0", mem_addr, 0);
      check("clr_in", mem_in, 0);
      busy_cnt = 1;
      guard = 0;
      while (clr_busy === 1'b1 && guard < 200) begin
         if (busy_cnt == 10) clr_start = 1'b1;   // must be ignored
         @(negedge clk);
         clr_start = 1'b0;
         guard++;
         if (clr_busy === 1'b1) busy_cnt++;
      end
      check("clr_cycles", 64'(busy_cnt), 64);
      check("clr_idle", req_ready, 1);
      for (int i = 0; i < 64; i++) do_read(6'(i), 64'h0, 0);

      // reset mid-clear at address 20
      for (int i = 0; i < 64; i++) do_write(6'(i), '1);
      @(negedge clk);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      guard = 0;
      while (!(clr_busy === 1'b1 && mem_addr == 6'd20) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("mc_at20", mem_addr, 6'd20);
      rst_n = 1'b0;
      #1;
      check("mc_busy", clr_busy, 0);
      check("mc_load", mem_load, 0);
      check("mc_addr", mem_addr, 0);
      check("mc_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 64; i++) check("mc_ram", ram[i], (i < 20) ? 64'h0 : '1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
